// File: rtl/add_stage_pkg.sv
// Shared types and widths for the add stage controller and its result FIFO.
package add_stage_pkg;

  localparam int DATA_W   = 32;
  localparam int OF_CNT_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              of;
  } res_t;

  function automatic logic [OF_CNT_W-1:0] of_cnt_sat_inc(input logic [OF_CNT_W-1:0] cnt);
    if (cnt == {OF_CNT_W{1'b1}}) begin
      return cnt;
    end else begin
      return cnt + {{(OF_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/add_stage_if.sv
// Operand, adder, result and overflow-status signals of add_stage_ctrl.
interface add_stage_if;
  import add_stage_pkg::*;

  logic                op_valid;
  logic                op_ready;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W-1:0]   add_in1;
  logic [DATA_W-1:0]   add_in2;
  logic [DATA_W-1:0]   add_sum;
  logic                add_cout;
  logic                add_of;
  logic                res_valid;
  logic                res_ready;
  logic [DATA_W-1:0]   res_sum;
  logic                res_cout;
  logic                res_of;
  logic                of_clr;
  logic                of_sticky;
  logic [OF_CNT_W-1:0] of_count;

  modport master (
    output op_valid, op_a, op_b, add_sum, add_cout, add_of, res_ready, of_clr,
    input  op_ready, add_in1, add_in2, res_valid, res_sum, res_cout, res_of,
           of_sticky, of_count
  );

  modport slave (
    input  op_valid, op_a, op_b, add_sum, add_cout, add_of, res_ready, of_clr,
    output op_ready, add_in1, add_in2, res_valid, res_sum, res_cout, res_of,
           of_sticky, of_count
  );

endinterface

// File: rtl/add_res_fifo.sv
// Synchronous FIFO of adder result records with occupancy count, full and empty.
// A pop on an empty FIFO is ignored; a push while full is taken only with a pop.
module add_res_fifo
  import add_stage_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  res_t             wr_data,
  input  logic             rd_en,
  output res_t             rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_fire_s, rd_fire_s;
  res_t             mem_q [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + {{(PTR_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign empty   = (count_q == {CNT_W{1'b0}});
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    rd_fire_s = rd_en && !empty;
    wr_fire_s = wr_en && (!full || rd_fire_s);
    wr_ptr_d  = wr_fire_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = rd_fire_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d   = count_q;
    case ({wr_fire_s, rd_fire_s})
      2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/add_stage_ctrl.sv
// Operand register feeding an external adder, with results buffered in a FIFO.
// Define ADD_STAGE_OF_COUNT_EN to build the saturating overflow counter.
module add_stage_ctrl
  import add_stage_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  add_stage_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              stage_valid_q, stage_valid_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic              of_sticky_q, of_sticky_d;
  logic [CNT_W-1:0]  fifo_count_s;
  logic [CNT_W-1:0]  occupancy_s;
  logic              fifo_full_s, fifo_empty_s;
  logic              op_ready_s, handshake_s, of_cap_s;
  res_t              wr_rec_s, rd_rec_s;

  // Readiness counts the result still in the stage, so a capture always finds room.
  always_comb begin
    occupancy_s = fifo_count_s + {{(CNT_W-1){1'b0}}, stage_valid_q};
    op_ready_s  = !fifo_full_s && (occupancy_s < CNT_W'(FIFO_DEPTH));
    handshake_s = bus.op_valid && op_ready_s;
    of_cap_s    = stage_valid_q && bus.add_of;
    wr_rec_s    = '{sum: bus.add_sum, cout: bus.add_cout, of: bus.add_of};
  end

  // Stage and sticky-flag next-state.
  always_comb begin
    stage_valid_d = handshake_s;
    if (handshake_s) begin
      op_a_d = bus.op_a;
      op_b_d = bus.op_b;
    end else begin
      op_a_d = op_a_q;
      op_b_d = op_b_q;
    end
    if (of_cap_s) begin
      of_sticky_d = 1'b1;
    end else if (bus.of_clr) begin
      of_sticky_d = 1'b0;
    end else begin
      of_sticky_d = of_sticky_q;
    end
  end

  // Stage and sticky-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid_q <= 1'b0;
      op_a_q        <= {DATA_W{1'b0}};
      op_b_q        <= {DATA_W{1'b0}};
      of_sticky_q   <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      of_sticky_q   <= of_sticky_d;
    end
  end

  add_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (stage_valid_q),
    .wr_data (wr_rec_s),
    .rd_en   (bus.res_ready),
    .rd_data (rd_rec_s),
    .count   (fifo_count_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

`ifdef ADD_STAGE_OF_COUNT_EN
  logic [OF_CNT_W-1:0] of_count_q, of_count_d;

  // A clear coinciding with an overflow capture counts that capture.
  always_comb begin
    if (bus.of_clr) begin
      of_count_d = of_cap_s ? {{(OF_CNT_W-1){1'b0}}, 1'b1} : {OF_CNT_W{1'b0}};
    end else if (of_cap_s) begin
      of_count_d = of_cnt_sat_inc(of_count_q);
    end else begin
      of_count_d = of_count_q;
    end
  end

  // Overflow counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      of_count_q <= {OF_CNT_W{1'b0}};
    end else begin
      of_count_q <= of_count_d;
    end
  end

  assign bus.of_count = of_count_q;
`else
  assign bus.of_count = {OF_CNT_W{1'b0}};
`endif

  assign bus.op_ready  = op_ready_s;
  assign bus.add_in1   = op_a_q;
  assign bus.add_in2   = op_b_q;
  assign bus.res_valid = !fifo_empty_s;
  assign bus.res_sum   = rd_rec_s.sum;
  assign bus.res_cout  = rd_rec_s.cout;
  assign bus.res_of    = rd_rec_s.of;
  assign bus.of_sticky = of_sticky_q;

endmodule

// File: tb/tb_add_stage_ctrl.sv
// Randomised and directed bench for add_stage_ctrl with a queue-based reference model.
module tb_add_stage_ctrl;
  import add_stage_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  add_stage_if bus ();

  add_stage_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Golden adder on the add_* ports.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_in1} + {1'b0, bus.add_in2};
  assign bus.add_of = (bus.add_in1[31] == bus.add_in2[31]) && (bus.add_sum[31] != bus.add_in1[31]);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: pending stage plus a queue of results in acceptance order.
  res_t        m_q[$];
  int          m_stage_v;
  logic [31:0] m_a, m_b;
  logic        m_sticky;
  int          m_cnt;

  function automatic res_t ref_add(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint unsigned u;
    longint s;
    u = longint'({32'd0, a}) + longint'({32'd0, b});
    s = longint'($signed(a)) + longint'($signed(b));
    r.sum  = u[31:0];
    r.cout = u[32];
    r.of   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_stage_v = 0;
      m_a = 32'd0;
      m_b = 32'd0;
      m_sticky = 1'b0;
      m_cnt = 0;
    end else begin
      int   sz;
      bit   hs, pop, cap_of;
      res_t r;
      sz = m_q.size();
      hs = bus.op_valid && ((sz + m_stage_v) < DEPTH);
      pop = bus.res_ready && (sz > 0);
      cap_of = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (m_stage_v != 0) begin
        r = ref_add(m_a, m_b);
        m_q.push_back(r);
        cap_of = r.of;
      end
      if (cap_of) m_sticky = 1'b1;
      else if (bus.of_clr) m_sticky = 1'b0;
`ifdef ADD_STAGE_OF_COUNT_EN
      if (bus.of_clr) m_cnt = cap_of ? 1 : 0;
      else if (cap_of && m_cnt < 255) m_cnt = m_cnt + 1;
`endif
      m_stage_v = hs ? 1 : 0;
      if (hs) begin
        m_a = bus.op_a;
        m_b = bus.op_b;
      end
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("op_ready", 64'(bus.op_ready), 64'((m_q.size() + m_stage_v) < DEPTH));
      check("res_valid", 64'(bus.res_valid), 64'(m_q.size() > 0));
      if (bus.res_valid && m_q.size() > 0) begin
        check("res_sum", 64'(bus.res_sum), 64'(m_q[0].sum));
        check("res_cout", 64'(bus.res_cout), 64'(m_q[0].cout));
        check("res_of", 64'(bus.res_of), 64'(m_q[0].of));
      end
      check("of_sticky", 64'(bus.of_sticky), 64'(m_sticky));
      check("of_count", 64'(bus.of_count), 64'(m_cnt));
      check("add_in1", 64'(bus.add_in1), 64'(m_a));
      check("add_in2", 64'(bus.add_in2), 64'(m_b));
    end
  end

  // Called at a negedge; returns at the negedge following the handshake edge.
  task automatic send_op(input logic [31:0] a, input logic [31:0] b);
    int w;
    bus.op_a = a;
    bus.op_b = b;
    bus.op_valid = 1'b1;
    w = 0;
    while (!bus.op_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("send_timeout", 64'(w), 64'(0));
    @(negedge clk);
    bus.op_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, cyc;
    logic [63:0] exp_one, exp_sat;
`ifdef ADD_STAGE_OF_COUNT_EN
    exp_one = 64'd1;
    exp_sat = 64'd255;
`else
    exp_one = 64'd0;
    exp_sat = 64'd0;
`endif
    bus.op_valid = 1'b0; bus.op_a = 32'd0; bus.op_b = 32'd0;
    bus.res_ready = 1'b0; bus.of_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_op_ready", 64'(bus.op_ready), 64'd1);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_add_in1", 64'(bus.add_in1), 64'd0);

    // Single op, overflow and carry.
    bus.res_ready = 1'b1;
    send_op(32'h0000_0005, 32'h0000_0003);
    @(negedge clk);
    check("single_valid", 64'(bus.res_valid), 64'd1);
    check("single_sum", 64'(bus.res_sum), 64'h8);
    check("single_cout_of", 64'({bus.res_cout, bus.res_of}), 64'd0);
    send_op(32'h7FFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    check("ovf_sum", 64'(bus.res_sum), 64'h8000_0000);
    check("ovf_of", 64'(bus.res_of), 64'd1);
    check("ovf_cout", 64'(bus.res_cout), 64'd0);
    check("ovf_sticky", 64'(bus.of_sticky), 64'd1);
    check("ovf_count", 64'(bus.of_count), exp_one);
    send_op(32'hFFFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    check("carry_sum", 64'(bus.res_sum), 64'd0);
    check("carry_cout", 64'(bus.res_cout), 64'd1);
    check("carry_of", 64'(bus.res_of), 64'd0);
    repeat (3) @(negedge clk);

    // Backpressure: exactly DEPTH accepted, then drained in order.
    bus.res_ready = 1'b0;
    bus.op_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      bus.op_a = 32'(100 + n);
      bus.op_b = 32'(n);
      if (bus.op_ready) n++;
      @(negedge clk);
    end
    check("bp_accepted", 64'(n), 64'(DEPTH));
    check("bp_op_ready", 64'(bus.op_ready), 64'd0);
    bus.op_valid = 1'b0;
    bus.res_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check("bp_drain_valid", 64'(bus.res_valid), 64'd1);
      check("bp_drain_sum", 64'(bus.res_sum), 64'(100 + 2 * k));
      @(negedge clk);
    end
    check("bp_drained", 64'(bus.res_valid), 64'd0);

    // Reset mid-stream with three results buffered.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_op(32'(10 + i), 32'd1);
    repeat (2) @(negedge clk);
    check("mid_buffered", 64'(bus.res_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("mid_rst_of_count", 64'(bus.of_count), 64'd0);
    check("mid_rst_add_in1", 64'(bus.add_in1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_op_ready", 64'(bus.op_ready), 64'd1);
    check("post_rst_res_valid", 64'(bus.res_valid), 64'd0);
    bus.res_ready = 1'b1;
    send_op(32'd1, 32'd1);
    @(negedge clk);
    check("post_rst_sum", 64'(bus.res_sum), 64'd2);

    // Randomised traffic.
    for (int c = 0; c < 600; c++) begin
      bus.op_valid  = ($urandom_range(0, 3) != 0);
      bus.res_ready = ($urandom_range(0, 2) != 0);
      bus.op_a      = pick_operand();
      bus.op_b      = pick_operand();
      bus.of_clr    = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    bus.op_valid = 1'b0; bus.of_clr = 1'b0; bus.res_ready = 1'b1;
    repeat (DEPTH + 3) @(negedge clk);

    // Overflow counter saturation and clear behaviour.
    bus.of_clr = 1'b1;
    @(negedge clk);
    bus.of_clr = 1'b0;
    bus.op_a = 32'h7FFF_FFFF;
    bus.op_b = 32'h0000_0001;
    bus.op_valid = 1'b1;
    n = 0; cyc = 0;
    while (n < 300 && cyc < 1000) begin
      if (bus.op_ready) n++;
      @(negedge clk);
      cyc++;
    end
    bus.op_valid = 1'b0;
    check("sat_accepted", 64'(n), 64'd300);
    repeat (3) @(negedge clk);
    check("sat_count", 64'(bus.of_count), exp_sat);
    check("sat_sticky", 64'(bus.of_sticky), 64'd1);
    send_op(32'h7FFF_FFFF, 32'h0000_0001);
    bus.of_clr = 1'b1;
    @(negedge clk);
    bus.of_clr = 1'b0;
    check("clr_cap_count", 64'(bus.of_count), exp_one);
    check("clr_cap_sticky", 64'(bus.of_sticky), 64'd1);
    bus.of_clr = 1'b1;
    @(negedge clk);
    bus.of_clr = 1'b0;
    check("clr_only_count", 64'(bus.of_count), 64'd0);
    check("clr_only_sticky", 64'(bus.of_sticky), 64'd0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/add_stage_ctrl.md
ADD_STAGE_CTRL -- requirements
Module: add_stage_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, 4, result FIFO entries; legal values 2, 4, 8, 16.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 op_valid  in  1  operand pair valid.
REQ-005 op_ready  out  1  operand pair accepted when op_valid and op_ready are both high.
REQ-006 op_a  in  32  first operand.
REQ-007 op_b  in  32  second operand.
REQ-008 add_in1  out  32  to the 32-bit adder in1.
REQ-009 add_in2  out  32  to the 32-bit adder in2.
REQ-010 add_sum  in  32  adder sum, combinational from add_in1/add_in2.
REQ-011 add_cout  in  1  adder carry-out.
REQ-012 add_of  in  1  adder signed overflow.
REQ-013 res_valid  out  1  FIFO head valid.
REQ-014 res_ready  in  1  consumer pops the head when res_valid and res_ready are both high.
REQ-015 res_sum / res_cout / res_of  out  32/1/1  FIFO head fields.
REQ-016 of_clr  in  1  clears of_sticky and of_count.
REQ-017 of_sticky  out  1  set by any captured result with of=1.
REQ-018 of_count  out  8  count of captured overflow results.

Function
REQ-019 Accept stage: on handshake, register op_a/op_b into the operand register and set stage_valid; otherwise clear stage_valid.
- add_in1/add_in2 driven only from the operand register.
REQ-020 Capture: in every cycle with stage_valid=1, write {add_sum, add_cout, add_of} into the FIFO at that clock edge.
REQ-021 Latency: handshake in cycle N gives res_valid=1 with that result in cycle N+2 (FIFO empty at N+1).
- Sustained throughput: one result per cycle.
REQ-022 op_ready = (fifo_count + stage_valid) < FIFO_DEPTH.
- Computed from registered state only.
- No combinational path from res_ready or op_valid.
REQ-023 FIFO never overflows.
- Write and pop in the same cycle when full: count unchanged.
- Pop when empty: ignored.
REQ-024 Results leave the FIFO in acceptance order.
- res_* holds stable while res_valid=1 and res_ready=0.
REQ-025 FIFO pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
REQ-026 Simultaneous write and pop on an empty FIFO: write takes effect, pop ignored.
REQ-027 of_sticky set on a captured result with of=1.
- Set has priority over of_clr in the same cycle.

Reset
REQ-028 rst asserted: immediately, without waiting for clk, drive to 0:
- stage_valid, fifo_count, pointers, res_valid, of_sticky, of_count
- operand register, so add_in1 = add_in2 = 0
REQ-029 Reset mid-operation discards in-flight and buffered results.
- First cycle after deassertion: op_ready=1, res_valid=0.

Configuration
REQ-030 ADD_STAGE_OF_COUNT_EN defined: of_count increments per captured result with of=1 and saturates at 255.
- of_clr with a simultaneous overflow capture: of_count loads 1.
- of_clr alone: of_count loads 0.
REQ-031 ADD_STAGE_OF_COUNT_EN undefined: of_count is constant 0 and has no counter flops; of_sticky is unaffected.

Structure
REQ-032 Package add_stage_pkg holds:
- DATA_W=32
- the result typedef {sum[31:0], cout, of}
- the of_count width constant 8
REQ-033 Sub-module add_res_fifo is the parameterised synchronous FIFO of result records with count, full and empty.
REQ-034 The 32-bit adder is external to this block.
- The bench instantiates a golden adder model on the add_* ports.

Verification
REQ-035 Single op: a=0x0000_0005, b=0x0000_0003, res_ready=1 -> two cycles later res_sum=0x0000_0008, res_cout=0, res_of=0.
REQ-036 Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001 -> res_sum=0x8000_0000, res_of=1, res_cout=0, of_sticky=1, of_count=1.
REQ-037 Carry: a=0xFFFF_FFFF, b=0x0000_0001 -> res_sum=0, res_cout=1, res_of=0.
REQ-038 Backpressure: res_ready=0, op_valid held high with FIFO_DEPTH=4 -> exactly 4 accepted, op_ready=0; release res_ready -> 4 results in order, one per cycle.
REQ-039 Reset mid-stream: 3 results buffered, assert rst -> res_valid=0, of_count=0, add_in1=0; after release, a new op=1+1 returns 2.
REQ-040 With ADD_STAGE_OF_COUNT_EN: 300 overflow ops -> of_count=255; of_clr together with an overflow capture -> of_count=1, of_sticky=1.
